// File: rtl/seq_multiplier_n.sv
// seq_multiplier_n: parametrised sequential shift-add multiplier.
// One iteration per clock while busy; product of two WIDTH-bit operands,
// unsigned or two's-complement selected per operation.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   start        request; accepted only in IDLE or DONE
//   signed_mode  1 = two's-complement operands, 0 = unsigned (sampled with start)
//   multiplicand operand B (sampled with start)
//   multiplier   operand Q (sampled with start)
//   busy         high while iterating
//   done         one-cycle pulse, result valid in the same cycle
//   result       last completed 2*WIDTH-bit product, held until next completion
module seq_multiplier_n #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [WIDTH:0]       r_a;
  logic [WIDTH-1:0]     r_b;
  logic [WIDTH-1:0]     r_q;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_smode;
  logic [2*WIDTH-1:0]   r_result;

  logic                 w_busy;
  logic                 w_done;
  logic                 w_load;
  logic                 w_last;
  logic                 w_sub;
  logic                 w_fill;
  logic [WIDTH:0]       w_ext_b;
  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_a_next;
  logic [WIDTH-1:0]     w_q_next;

  // Iteration datapath. A carries one extra bit so unsigned sums keep their
  // carry and signed sums keep their true sign before the arithmetic shift.
  assign w_last   = (r_cnt == LAST);
  assign w_ext_b  = r_smode ? {r_b[WIDTH-1], r_b} : {1'b0, r_b};
  // The multiplier MSB has negative weight in two's complement, so the final
  // partial product is subtracted instead of added.
  assign w_sub    = r_smode & r_q[0] & w_last;
  assign w_sum    = !r_q[0] ? r_a : (w_sub ? (r_a - w_ext_b) : (r_a + w_ext_b));
  assign w_fill   = r_smode & w_sum[WIDTH];
  assign w_a_next = {w_fill, w_sum[WIDTH:1]};
  assign w_q_next = {w_sum[0], r_q[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    w_load       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load       = 1'b1;
          w_state_next = S_CALC;
        end
      end
      S_CALC: begin
        w_busy = 1'b1;
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_done = 1'b1;
        if (start) begin
          w_load       = 1'b1;
          w_state_next = S_CALC;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_q      <= '0;
      r_cnt    <= '0;
      r_smode  <= 1'b0;
      r_result <= '0;
    end else if (w_load) begin
      r_a     <= '0;
      r_b     <= multiplicand;
      r_q     <= multiplier;
      r_smode <= signed_mode;
      r_cnt   <= '0;
    end else if (r_state == S_CALC) begin
      r_a   <= w_a_next;
      r_q   <= w_q_next;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_result <= {w_a_next[WIDTH-1:0], w_q_next};
      end
    end
  end

  assign busy   = w_busy;
  assign done   = w_done;
  assign result = r_result;

endmodule
